// File: rtl/heatwave_if.sv
// Sample strobe in, alarm status and event statistics out.
interface heatwave_if #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned CNT_W  = 8
) ();
  logic              sample_valid;
  logic [DATA_W-1:0] avg_temp;
  logic              heat_alarm;
  logic              alarm_rise;
  logic              alarm_fall;
  logic [1:0]        state;
  logic [CNT_W-1:0]  run_len;
  logic [DATA_W-1:0] peak_temp;
  logic [CNT_W-1:0]  event_count;

  // Producer side: moving-average stage plus display/alert consumers
  modport master (
    output sample_valid, avg_temp,
    input  heat_alarm, alarm_rise, alarm_fall, state, run_len, peak_temp, event_count
  );

  // Detector side
  modport slave (
    input  sample_valid, avg_temp,
    output heat_alarm, alarm_rise, alarm_fall, state, run_len, peak_temp, event_count
  );
endinterface

// File: rtl/heatwave_detector.sv
// Hysteresis detector: declares a heatwave after ONSET_COUNT consecutive hot
// samples and clears it after CLEAR_COUNT consecutive cool samples.
module heatwave_detector #(
  parameter int unsigned       DATA_W       = 11,
  parameter logic [DATA_W-1:0] HOT_THRESH   = DATA_W'(400),
  parameter logic [DATA_W-1:0] CLEAR_THRESH = DATA_W'(350),
  parameter int unsigned       ONSET_COUNT  = 3,
  parameter int unsigned       CLEAR_COUNT  = 3,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  heatwave_if.slave  bus
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    WARMING  = 2'd1,
    HEATWAVE = 2'd2,
    COOLING  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hot_cnt_q, hot_cnt_d;
  logic [CNT_W-1:0]  cool_cnt_q, cool_cnt_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;
  logic [CNT_W-1:0]  event_count_q, event_count_d;
  logic [DATA_W-1:0] peak_temp_q, peak_temp_d;
  logic              heat_alarm_q, heat_alarm_d;
  logic              alarm_rise_q, alarm_rise_d;
  logic              alarm_fall_q, alarm_fall_d;

  logic             is_hot, is_cool, onset_hit, clear_hit;
  logic [CNT_W-1:0] hot_inc, cool_inc, run_inc, event_inc;

  // Sample classification and saturating increments
  always_comb begin
    is_hot    = bus.avg_temp >= HOT_THRESH;
    is_cool   = bus.avg_temp <= CLEAR_THRESH;
    hot_inc   = hot_cnt_q + CNT_ONE;
    cool_inc  = cool_cnt_q + CNT_ONE;
    onset_hit = hot_inc == CNT_W'(ONSET_COUNT);
    clear_hit = cool_inc == CNT_W'(CLEAR_COUNT);
    run_inc   = (run_len_q == CNT_MAX) ? run_len_q : run_len_q + CNT_ONE;
    event_inc = (event_count_q == CNT_MAX) ? event_count_q : event_count_q + CNT_ONE;
  end

  // State register and all registered outputs; reset discards any event
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= NORMAL;
      hot_cnt_q     <= '0;
      cool_cnt_q    <= '0;
      run_len_q     <= '0;
      event_count_q <= '0;
      peak_temp_q   <= '0;
      heat_alarm_q  <= 1'b0;
      alarm_rise_q  <= 1'b0;
      alarm_fall_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hot_cnt_q     <= hot_cnt_d;
      cool_cnt_q    <= cool_cnt_d;
      run_len_q     <= run_len_d;
      event_count_q <= event_count_d;
      peak_temp_q   <= peak_temp_d;
      heat_alarm_q  <= heat_alarm_d;
      alarm_rise_q  <= alarm_rise_d;
      alarm_fall_q  <= alarm_fall_d;
    end
  end

  // Next-state: transitions only on a valid sample
  always_comb begin
    state_d = state_q;
    if (bus.sample_valid) begin
      unique case (state_q)
        NORMAL:   if (is_hot) state_d = WARMING;
        WARMING:  if (!is_hot) state_d = NORMAL;
                  else if (onset_hit) state_d = HEATWAVE;
        HEATWAVE: if (is_cool) state_d = COOLING;
        COOLING:  if (!is_cool) state_d = HEATWAVE;
                  else if (clear_hit) state_d = NORMAL;
        default:  state_d = NORMAL;
      endcase
    end
  end

  // Counters, statistics and pulses; everything holds without a strobe
  always_comb begin
    hot_cnt_d     = hot_cnt_q;
    cool_cnt_d    = cool_cnt_q;
    run_len_d     = run_len_q;
    event_count_d = event_count_q;
    peak_temp_d   = peak_temp_q;
    alarm_rise_d  = 1'b0;
    alarm_fall_d  = 1'b0;
    heat_alarm_d  = (state_d == HEATWAVE) || (state_d == COOLING);
    if (bus.sample_valid) begin
      if ((state_q != NORMAL) && (bus.avg_temp > peak_temp_q)) begin
        peak_temp_d = bus.avg_temp;
      end
      unique case (state_q)
        NORMAL: begin
          if (is_hot) begin
            hot_cnt_d   = CNT_ONE;
            run_len_d   = CNT_ONE;
            peak_temp_d = bus.avg_temp;
          end
        end
        WARMING: begin
          if (is_hot) begin
            hot_cnt_d = hot_inc;
            run_len_d = run_inc;
            if (onset_hit) begin
              alarm_rise_d  = 1'b1;
              event_count_d = event_inc;
            end
          end else begin
            hot_cnt_d = '0;
          end
        end
        HEATWAVE: begin
          run_len_d  = run_inc;
          cool_cnt_d = is_cool ? CNT_ONE : '0;
        end
        COOLING: begin
          run_len_d = run_inc;
          if (!is_cool) begin
            cool_cnt_d = '0;
          end else if (clear_hit) begin
            alarm_fall_d = 1'b1;
            hot_cnt_d    = '0;
            cool_cnt_d   = '0;
          end else begin
            cool_cnt_d = cool_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.heat_alarm  = heat_alarm_q;
  assign bus.alarm_rise  = alarm_rise_q;
  assign bus.alarm_fall  = alarm_fall_q;
  assign bus.state       = state_q;
  assign bus.run_len     = run_len_q;
  assign bus.peak_temp   = peak_temp_q;
  assign bus.event_count = event_count_q;

endmodule

// File: tb/tb_heatwave_detector.sv
// Self-checking bench for heatwave_detector against a streak-based model.
module tb_heatwave_detector;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned CNT_W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  heatwave_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  heatwave_detector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Model: alarm flag, current hot/cool streak lengths, event statistics
  bit m_alarm, m_rise, m_fall;
  int m_hot_run, m_cool_run, m_run, m_peak, m_evt;

  function automatic logic [31:0] dut_vec();
    return {bus.heat_alarm, bus.alarm_rise, bus.alarm_fall, bus.state,
            bus.run_len, bus.peak_temp, bus.event_count};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [1:0] st;
    if (m_alarm) st = (m_cool_run > 0) ? 2'd3 : 2'd2;
    else         st = (m_hot_run > 0) ? 2'd1 : 2'd0;
    return {m_alarm, m_rise, m_fall, st, 8'(m_run), 11'(m_peak), 8'(m_evt)};
  endfunction

  task automatic model_reset();
    m_alarm = 0; m_rise = 0; m_fall = 0;
    m_hot_run = 0; m_cool_run = 0; m_run = 0; m_peak = 0; m_evt = 0;
  endtask

  task automatic model_sample(input int t);
    bit hot, cool;
    hot  = (t >= 400);
    cool = (t <= 350);
    m_rise = 0;
    m_fall = 0;
    if (!m_alarm) begin
      if (!hot) begin
        m_hot_run = 0;
      end else if (m_hot_run == 0) begin
        m_hot_run = 1; m_run = 1; m_peak = t;
      end else begin
        m_hot_run++;
        m_run = (m_run < 255) ? m_run + 1 : 255;
        if (t > m_peak) m_peak = t;
        if (m_hot_run == 3) begin
          m_alarm = 1; m_rise = 1; m_cool_run = 0;
          m_evt = (m_evt < 255) ? m_evt + 1 : 255;
        end
      end
    end else begin
      m_run = (m_run < 255) ? m_run + 1 : 255;
      if (t > m_peak) m_peak = t;
      if (cool) begin
        m_cool_run++;
        if (m_cool_run == 3) begin
          m_alarm = 0; m_fall = 1; m_hot_run = 0; m_cool_run = 0;
        end
      end else begin
        m_cool_run = 0;
      end
    end
  endtask

  // One clock: drive at a falling edge, result visible at the next one
  task automatic step(input bit v, input int t);
    bus.sample_valid = v;
    bus.avg_temp     = DATA_W'(t);
    @(negedge clk);
    if (v) model_sample(t);
    else begin m_rise = 0; m_fall = 0; end
  endtask

  task automatic step_reset(input bit v, input int t);
    reset            = 1'b0;
    bus.sample_valid = v;
    bus.avg_temp     = DATA_W'(t);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    step_reset(1'b1, 420);
    got = dut_vec();
    n_cmp++;
    if (got !== 32'h0) begin
      n_mis++; $display("FAIL reset_state: got %h expected %h", got, 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 300);
      got = dut_vec(); exp = model_vec();
      n_cmp++;
      if (got !== exp) begin
        n_mis++; $display("FAIL normal_300[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_onset();
    int          temps[3]  = '{410, 420, 430};
    logic [1:0]  states[3] = '{2'd1, 2'd1, 2'd2};
    logic [31:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, temps[i]);
      got = dut_vec(); exp = model_vec();
      n_cmp++;
      if (got !== exp || bus.state !== states[i]) begin
        n_mis++; $display("FAIL onset[%0d]: got %h state %0d expected %h state %0d",
                          i, got, bus.state, exp, states[i]);
      end
    end
    n_cmp++;
    if (bus.alarm_rise !== 1'b1 || bus.event_count !== 8'd1 ||
        bus.peak_temp !== 11'd430 || bus.run_len !== 8'd3) begin
      n_mis++; $display("FAIL onset_stats: got rise %b evt %0d peak %0d run %0d expected 1 1 430 3",
                        bus.alarm_rise, bus.event_count, bus.peak_temp, bus.run_len);
    end
    step(1'b0, 999);
    n_cmp++;
    if (bus.alarm_rise !== 1'b0 || bus.heat_alarm !== 1'b1) begin
      n_mis++; $display("FAIL rise_width: got rise %b alarm %b expected 0 1",
                        bus.alarm_rise, bus.heat_alarm);
    end
  endtask

  task automatic test_clear();
    int          temps[6]  = '{340, 340, 380, 340, 340, 340};
    logic [1:0]  states[6] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [31:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, temps[i]);
      got = dut_vec(); exp = model_vec();
      n_cmp++;
      if (got !== exp || bus.state !== states[i] || bus.alarm_fall !== (i == 5)) begin
        n_mis++; $display("FAIL clear[%0d]: got %h state %0d expected %h state %0d",
                          i, got, bus.state, exp, states[i]);
      end
    end
    n_cmp++;
    if (bus.run_len !== 8'd9 || bus.heat_alarm !== 1'b0) begin
      n_mis++; $display("FAIL clear_run_len: got %0d alarm %b expected 9 0",
                        bus.run_len, bus.heat_alarm);
    end
  endtask

  task automatic test_false_start();
    int          temps[4]  = '{410, 420, 390, 375};
    logic [1:0]  states[4] = '{2'd1, 2'd1, 2'd0, 2'd0};
    logic [31:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, temps[i]);
      got = dut_vec(); exp = model_vec();
      n_cmp++;
      if (got !== exp || bus.state !== states[i] || bus.event_count !== 8'd1 ||
          bus.heat_alarm !== 1'b0) begin
        n_mis++; $display("FAIL false_start[%0d]: got %h state %0d expected %h state %0d",
                          i, got, bus.state, exp, states[i]);
      end
    end
  endtask

  task automatic test_reset_mid_event();
    logic [31:0] got;
    step(1'b1, 410); step(1'b1, 420); step(1'b1, 430); step(1'b1, 340);
    n_cmp++;
    if (bus.state !== 2'd3) begin
      n_mis++; $display("FAIL pre_reset_state: got %0d expected 3", bus.state);
    end
    step_reset(1'b1, 340);
    got = dut_vec();
    n_cmp++;
    if (got !== 32'h0) begin
      n_mis++; $display("FAIL reset_mid_event: got %h expected %h", got, 32'h0);
    end
    step(1'b0, 340);
    got = dut_vec();
    n_cmp++;
    if (got !== 32'h0) begin
      n_mis++; $display("FAIL reset_no_fall: got %h expected %h", got, 32'h0);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] got, exp;
    step(1'b1, 410); step(1'b1, 420); step(1'b1, 430);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, int'($urandom_range(400, 2047)));
      got = dut_vec(); exp = model_vec();
      n_cmp++;
      if (got !== exp) begin
        n_mis++; $display("FAIL sat_sample[%0d]: got %h expected %h", i, got, exp);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step(1'b0, int'($urandom_range(0, 2047)));
        got = dut_vec(); exp = model_vec();
        n_cmp++;
        if (got !== exp) begin
          n_mis++; $display("FAIL sat_gap[%0d]: got %h expected %h", i, got, exp);
        end
      end
    end
    n_cmp++;
    if (bus.run_len !== 8'd255 || bus.state !== 2'd2) begin
      n_mis++; $display("FAIL run_len_sat: got %0d state %0d expected 255 2",
                        bus.run_len, bus.state);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    step_reset(1'b0, 0);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(320, 440)));
      got = dut_vec(); exp = model_vec();
      n_cmp++;
      if (got !== exp) begin
        n_mis++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.avg_temp     = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_onset();
    test_clear();
    test_false_start();
    test_reset_mid_event();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
